// File: rtl/tx_machine_pkg.sv
// -----------------------------------------------------------------------------
// tx_machine_pkg
// Shared definitions for the tx_machine byte-to-bit serializer.
//   state_t            : FSM state encoding (idle, shifting, hold-off)
//   DEF_DATA_WIDTH     : default parallel word width / bits per transfer
//   DEF_IDLE_LEVEL     : default txd level outside a transfer
// -----------------------------------------------------------------------------
package tx_machine_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam logic        DEF_IDLE_LEVEL = 1'b0;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StHold  = 2'd2
    } state_t;

endpackage : tx_machine_pkg

// File: rtl/tx_machine.sv
// -----------------------------------------------------------------------------
// tx_machine
// Byte-to-bit serializer. A 0->1 transition on send captures data and shifts
// it out on txd, one bit per clock, LSB first, no start/stop bits.
//
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   asynchronous active-low reset
//   send  in   transfer request (level; a rising edge starts a transfer)
//   data  in   parallel word, sampled only on the accepting edge
//   txd   out  registered serial output
// -----------------------------------------------------------------------------
module tx_machine
    import tx_machine_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter logic        IDLE_LEVEL = DEF_IDLE_LEVEL
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  send,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  txd
);

    localparam int unsigned      CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    state_t                  r_state;
    logic [DATA_WIDTH-1:0]   r_sh;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_send_d;
    logic                    r_armed;
    logic                    r_txd;
    logic                    w_req;

    // r_send_d resets to 0, so a send already high at reset release would
    // look like an edge. r_armed only sets once send has been seen low,
    // which keeps a level held through reset from starting a transfer.
    assign w_req = send & ~r_send_d & r_armed;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= StIdle;
            r_sh     <= '0;
            r_cnt    <= '0;
            r_send_d <= 1'b0;
            r_armed  <= 1'b0;
            r_txd    <= IDLE_LEVEL;
        end else begin
            r_send_d <= send;
            if (!send) begin
                r_armed <= 1'b1;
            end

            case (r_state)
                StIdle: begin
                    r_txd <= IDLE_LEVEL;
                    if (w_req) begin
                        r_sh    <= data;
                        r_cnt   <= '0;
                        r_state <= StShift;
                    end
                end

                StShift: begin
                    // Requests are ignored here; only the captured copy is sent.
                    r_txd <= r_sh[r_cnt];
                    if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= StHold;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                StHold: begin
                    // Wait for send to drop so a held level never re-triggers.
                    r_txd <= IDLE_LEVEL;
                    if (!send) begin
                        r_state <= StIdle;
                    end
                end

                default: begin
                    r_txd   <= IDLE_LEVEL;
                    r_cnt   <= '0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign txd = r_txd;

endmodule : tx_machine

// File: tb/tb_tx_machine.sv
// -----------------------------------------------------------------------------
// tb_tx_machine
// Directed bench for tx_machine. Expected txd values are queued when a
// request is driven and popped one per clock; an empty queue means idle.
// -----------------------------------------------------------------------------
module tb_tx_machine;

    localparam int unsigned DW   = 8;
    localparam logic        IDLE = 1'b0;

    logic          clk  = 1'b0;
    logic          rst  = 1'b1;
    logic          send = 1'b0;
    logic [DW-1:0] data = '0;
    logic          txd;

    int   checks = 0;
    int   errors = 0;
    logic exp_q[$];

    tx_machine #(
        .DATA_WIDTH (DW),
        .IDLE_LEVEL (IDLE)
    ) u_dut (
        .clk  (clk),
        .rst  (rst),
        .send (send),
        .data (data),
        .txd  (txd)
    );

    always #5 clk = ~clk;

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [DW-1:0] obs,
                          input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected txd after the accepting edge (idle) then each bit LSB first.
    task automatic push_byte(input logic [DW-1:0] b);
        exp_q.push_back(IDLE);
        for (int i = 0; i < int'(DW); i++) begin
            exp_q.push_back(b[i]);
        end
    endtask

    // One clock: sample #1 after the rising edge and compare to the scoreboard.
    task automatic step(input string tag);
        logic e;
        @(posedge clk);
        #1;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE;
        check1(tag, txd, e);
    endtask

    initial begin : stim
        logic [DW-1:0] hello[7];
        logic [DW-1:0] rx;

        hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h21, 8'h21};

        // Reset held for 3 cycles with send toggling.
        #2 rst = 1'b0;
        #1 check1("reset_async_txd", txd, IDLE);
        for (int i = 0; i < 3; i++) begin
            send = ~send;
            data = 8'hFF;
            step("reset_hold");
        end
        send = 1'b0;
        rst  = 1'b1;
        for (int i = 0; i < 4; i++) step("reset_release_idle");

        // Single byte, one-cycle pulse.
        data = 8'hA5;
        send = 1'b1;
        push_byte(8'hA5);
        step("a5_accept");
        send = 1'b0;
        for (int i = 0; i < 12; i++) step("a5_bits");

        // Held request: exactly one transfer.
        data = 8'h3C;
        send = 1'b1;
        push_byte(8'h3C);
        for (int i = 0; i < 20; i++) step("held_3c");
        send = 1'b0;
        for (int i = 0; i < 4; i++) step("held_release");

        // Back-to-back "Hello!!", send high 3 cycles every 10.
        for (int b = 0; b < 7; b++) begin
            data = hello[b];
            send = 1'b1;
            push_byte(hello[b]);
            rx = '0;
            for (int c = 0; c < 10; c++) begin
                step("hello_bit");
                if (c >= 1 && c <= int'(DW)) rx[c-1] = txd;
                if (c == 2) send = 1'b0;
            end
            check8("hello_byte", rx, hello[b]);
        end
        for (int i = 0; i < 3; i++) step("hello_tail");

        // Ignored re-request during shift, with data changed.
        data = 8'hFF;
        send = 1'b1;
        push_byte(8'hFF);
        step("ff_accept");
        send = 1'b0;
        for (int i = 0; i < 3; i++) step("ff_bits");
        data = 8'h00;
        send = 1'b1;
        step("ff_repulse");
        send = 1'b0;
        for (int i = 0; i < 16; i++) step("ff_no_second");

        // Async abort mid-bit 4 of F0.
        data = 8'hF0;
        send = 1'b1;
        push_byte(8'hF0);
        step("f0_accept");
        send = 1'b0;
        for (int i = 0; i < 5; i++) step("f0_bits");
        check1("f0_bit4_before_abort", txd, 1'b1);
        #2 rst = 1'b0;
        #1 check1("abort_async_txd", txd, IDLE);
        exp_q.delete();
        step("abort_hold");
        rst = 1'b1;
        for (int i = 0; i < 12; i++) step("abort_no_resume");

        data = 8'h81;
        send = 1'b1;
        push_byte(8'h81);
        step("x81_accept");
        send = 1'b0;
        for (int i = 0; i < 11; i++) step("x81_bits");

        // send already high at reset release must not start a transfer.
        rst  = 1'b0;
        send = 1'b1;
        data = 8'hFF;
        step("prerel_reset");
        rst = 1'b1;
        for (int i = 0; i < 12; i++) step("prerel_no_xfer");
        send = 1'b0;
        step("prerel_drop");
        data = 8'h01;
        send = 1'b1;
        push_byte(8'h01);
        step("x01_accept");
        send = 1'b0;
        for (int i = 0; i < 10; i++) step("x01_bits");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_tx_machine
